// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised asynchronous serial receiver.
// Two-flop input synchronizer, majority-vote mid-bit sampling, false-start
// rejection, optional parity, one or two stop bits, and a single-entry
// valid/ready output holding register with parity/framing/overrun flags.
//
// Bit timing: r_cnt is cleared on the edge that enters START and then counts
// 0..CLKS_PER_BIT-1 continuously for the whole frame. "Phase n" of a bit is
// the edge that advances r_cnt to n. The three votes are the synchronized
// line at phases HALF-1, HALF and HALF+1; the bit is decided at phase HALF+1
// (the decision edge), where the third vote is taken live from the line.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,  // clock cycles per bit, >= 8
  parameter int DATA_BITS    = 8,    // 5..9, LSB first
  parameter int PARITY       = 0,    // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  // Counter values seen *before* the phase HALF-1 / HALF / HALF+1 edges.
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_VOTE0 = CW'(HALF - 2);
  localparam logic [CW-1:0] CNT_VOTE1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_DEC   = CW'(HALF);

  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic                 r_armed;
  logic [CW-1:0]        r_cnt;
  logic                 r_vote0;
  logic                 r_vote1;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic                 r_perr_acc;
  logic                 r_ferr_acc;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  logic w_dec;
  logic w_bit;
  logic w_last_data;
  logic w_last_stop;
  logic w_start_ok;
  logic w_data_shift;
  logic w_parity_chk;
  logic w_stop_sample;
  logic w_done;

  assign w_rx_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  // Bit-phase counter: held at 0 in IDLE, free-running and wrapping in a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture the first two majority votes ahead of the decision edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else begin
      if (r_cnt == CNT_VOTE0) r_vote0 <= w_rx_s;
      if (r_cnt == CNT_VOTE1) r_vote1 <= w_rx_s;
    end
  end

  // Decision strobe and majority of the three votes (third vote is live).
  always_comb begin
    w_dec       = (r_state != S_IDLE) && (r_cnt == CNT_DEC);
    w_bit       = (r_vote0 & r_vote1) | (r_vote0 & w_rx_s) | (r_vote1 & w_rx_s);
    w_last_data = (r_bit_idx == IDX_LAST);
    w_last_stop = (r_stop_idx == STOP_LAST);
  end

  // Armed flag: only a line seen high in IDLE may start a frame, so a held-low
  // line (break, or low after reset) never triggers a reception.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_armed <= 1'b0;
    end else if (r_armed && !w_rx_s) begin
      r_armed <= 1'b0;
    end else if (w_rx_s) begin
      r_armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; every bit transition happens on its decision edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_dec) w_state_next = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_dec && w_last_data) w_state_next = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_dec) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_dec && w_last_stop) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and per-state datapath strobes.
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    w_start_ok    = 1'b0;
    w_data_shift  = 1'b0;
    w_parity_chk  = 1'b0;
    w_stop_sample = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_START:  w_start_ok   = w_dec && !w_bit;
      S_DATA:   w_data_shift = w_dec;
      S_PARITY: w_parity_chk = w_dec;
      S_STOP: begin
        w_stop_sample = w_dec;
        w_done        = w_dec && w_last_stop;
      end
      default: ;
    endcase
  end

  // Frame datapath: LSB-first shift, bit/stop indices and error accumulators,
  // all cleared once a start bit is confirmed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_perr_acc <= 1'b0;
        r_ferr_acc <= 1'b0;
      end
      if (w_data_shift) begin
        // After DATA_BITS shifts the first bit received sits at bit 0.
        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + IW'(1);
      end
      if (w_parity_chk) begin
        // XOR over data and parity bit is 1 for odd parity, 0 for even.
        r_perr_acc <= (^r_shift ^ w_bit) ^ ODD_PAR;
      end
      if (w_stop_sample) begin
        r_stop_idx <= r_stop_idx + 1'b1;
        if (!w_bit) r_ferr_acc <= 1'b1;
      end
    end
  end

  // Output holding register: load on completion when free or being accepted
  // on the same edge, otherwise drop the new word and flag overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || i_ready) begin
        r_data  <= r_shift;
        r_perr  <= r_perr_acc;
        r_ferr  <= r_ferr_acc | ~w_bit;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr   <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: two instances (8N1 and 7E2, 16 clocks/bit),
// directed timing/boundary cases plus randomized frames, checked by
// per-instance scoreboards drained by independent output monitors.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;

  logic       a_rx, a_ready, a_valid, a_perr, a_ferr, a_ovr, a_busy;
  logic [7:0] a_data;
  logic       b_rx, b_ready, b_valid, b_perr, b_ferr, b_ovr, b_busy;
  logic [6:0] b_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   a_held = 1'b0;

  int a_vrise = 0, a_vhigh = 0, a_brise = 0, a_bfall = 0, a_brise_cnt = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(a_rx), .o_data(a_data), .o_valid(a_valid),
    .i_ready(a_ready), .o_parity_err(a_perr), .o_frame_err(a_ferr),
    .o_overrun(a_ovr), .o_busy(a_busy)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(b_rx), .o_data(b_data), .o_valid(b_valid),
    .i_ready(b_ready), .o_parity_err(b_perr), .o_frame_err(b_ferr),
    .o_overrun(b_ovr), .o_busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive nbits (LSB first) one bit period each, then idle_bits of high line.
  task automatic send_bits(input bit sel_b, input logic [15:0] bits, input int nbits,
                           input int idle_bits);
    for (int i = 0; i < nbits; i++) begin
      if (sel_b) b_rx = bits[i]; else a_rx = bits[i];
      wait_cyc(CPB);
    end
    if (idle_bits > 0) begin
      if (sel_b) b_rx = 1'b1; else a_rx = 1'b1;
      wait_cyc(idle_bits * CPB);
    end
  endtask

  // 8N1 frame; a word completing while the previous one is still unaccepted
  // is lost and turns the held word's overrun flag on.
  task automatic frame_a(input logic [7:0] d, input logic stop, input int idle_bits);
    exp_t e;
    e.data = {1'b0, d};
    e.perr = 1'b0;
    e.ferr = ~stop;
    e.ovr  = 1'b0;
    if (a_held) begin
      e = qa.pop_back();
      e.ovr = 1'b1;
      qa.push_back(e);
    end else begin
      qa.push_back(e);
      a_held = !a_ready;
    end
    send_bits(1'b0, {6'b0, stop, d, 1'b0}, 10, idle_bits);
  endtask

  // 7E2 frame; flip inverts the correct even-parity bit.
  task automatic frame_b(input logic [6:0] d, input logic flip, input logic s0,
                         input logic s1, input int idle_bits);
    exp_t e;
    logic p;
    p = ((($countones(d)) % 2) == 1) ^ flip;
    e.data = {2'b0, d};
    e.perr = ((($countones(d) + int'(p)) % 2) != 0);
    e.ferr = !(s0 && s1);
    e.ovr  = 1'b0;
    qb.push_back(e);
    send_bits(1'b1, {5'b0, s1, s0, p, d, 1'b0}, 11, idle_bits);
  endtask

  // Monitor A: edge timing records and scoreboard pop on each acceptance.
  initial begin : mon_a
    exp_t e;
    logic pv, pb;
    pv = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (a_valid && !pv) a_vrise = cyc;
      if (a_valid) a_vhigh++;
      if (a_busy && !pb) begin
        a_brise = cyc;
        a_brise_cnt++;
      end
      if (!a_busy && pb) a_bfall = cyc;
      pv = a_valid;
      pb = a_busy;
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected: got word 0x%0h, required no word", a_data);
        end else begin
          e = qa.pop_front();
          $display("[TB] A word 0x%02h perr=%0d ferr=%0d ovr=%0d", a_data, a_perr, a_ferr, a_ovr);
          chk("a_data", 32'(a_data), 32'(e.data));
          chk("a_parity_err", 32'(a_perr), 32'(e.perr));
          chk("a_frame_err", 32'(a_ferr), 32'(e.ferr));
          chk("a_overrun", 32'(a_ovr), 32'(e.ovr));
        end
      end
    end
  end

  // Monitor B: scoreboard pop on each acceptance.
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected: got word 0x%0h, required no word", b_data);
        end else begin
          e = qb.pop_front();
          $display("[TB] B word 0x%02h perr=%0d ferr=%0d ovr=%0d", b_data, b_perr, b_ferr, b_ovr);
          chk("b_data", 32'(b_data), 32'(e.data));
          chk("b_parity_err", 32'(b_perr), 32'(e.perr));
          chk("b_frame_err", 32'(b_ferr), 32'(e.ferr));
          chk("b_overrun", 32'(b_ovr), 32'(e.ovr));
        end
      end
    end
  end

  initial begin : stim
    int          c0;
    int          vr;
    int          bc;
    logic [31:0] r;

    rst_n   = 1'b0;
    a_rx    = 1'b1;
    b_rx    = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_data", 32'(a_data), 0);
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_a_flags", {29'b0, a_perr, a_ferr, a_ovr}, 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);

    // 0xA5: start enters at c0+3, valid for exactly one cycle after T+153.
    a_vhigh = 0;
    c0 = cyc;
    frame_a(8'hA5, 1'b1, 2);
    chk("a5_valid_rise", 32'(a_vrise - c0), 156);
    chk("a5_valid_len", 32'(a_vhigh), 1);
    chk("a5_busy_rise", 32'(a_brise - c0), 3);
    chk("a5_busy_fall", 32'(a_bfall - c0), 156);

    // False start: line low for 5 cycles aborts at T+9.
    c0 = cyc;
    vr = a_vrise;
    a_rx = 1'b0;
    wait_cyc(5);
    a_rx = 1'b1;
    wait_cyc(3 * CPB);
    chk("fs_busy_rise", 32'(a_brise - c0), 3);
    chk("fs_busy_fall", 32'(a_bfall - c0), 12);
    chk("fs_no_valid", 32'(a_vrise), 32'(vr));

    // Framing error followed by a 40-bit break, then a clean frame.
    frame_a(8'h3C, 1'b0, 0);
    bc = a_brise_cnt;
    wait_cyc(40 * CPB);
    chk("break_no_retrigger", 32'(a_brise_cnt), 32'(bc));
    chk("break_busy", 32'(a_busy), 0);
    a_rx = 1'b1;
    wait_cyc(2 * CPB);
    frame_a(8'h81, 1'b1, 2);

    // Overrun: consumer stalled across two frames.
    a_ready = 1'b0;
    frame_a(8'h11, 1'b1, 2);
    frame_a(8'h22, 1'b1, 2);
    chk("ovr_valid_held", 32'(a_valid), 1);
    chk("ovr_data_held", 32'(a_data), 32'h11);
    chk("ovr_flag", 32'(a_ovr), 1);
    a_ready = 1'b1;
    a_held  = 1'b0;
    wait_cyc(1);
    chk("ovr_valid_clear", 32'(a_valid), 0);
    chk("ovr_flag_clear", 32'(a_ovr), 0);

    // Reset in the middle of the data bits of 0xFF.
    a_rx = 1'b0;
    wait_cyc(CPB);
    a_rx = 1'b1;
    wait_cyc(4 * CPB);
    chk("midrst_pre_busy", 32'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(a_data), 0);
    chk("midrst_valid", 32'(a_valid), 0);
    chk("midrst_busy", 32'(a_busy), 0);
    chk("midrst_flags", {29'b0, a_perr, a_ferr, a_ovr}, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 * CPB);
    frame_a(8'h5A, 1'b1, 2);

    // Randomized 8N1 traffic with occasional bad stop bits.
    repeat (12) begin
      r = $urandom;
      frame_a(r[7:0], (r[10:8] != 3'd0), int'(r[12:11]) + 1);
    end

    // 7E2: wrong parity bit on 0x37, then randomized traffic.
    frame_b(7'h37, 1'b1, 1'b1, 1'b1, 2);
    repeat (12) begin
      r = $urandom;
      frame_b(r[6:0], r[7], (r[9:8] != 2'd0), (r[11:10] != 2'd0), int'(r[13:12] == 2'd0) + 1);
    end

    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) wait_cyc(1);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
